// File: rtl/gpu_task_dispatcher.sv
// gpu_task_dispatcher: holds a 16-word program and streams it to each selected
// core in turn, then waits until every loaded core reports ready.
module gpu_task_dispatcher #(
   parameter int NUM_CORES  = 16,
   parameter int PROG_WORDS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 prog_we,
   input  logic [3:0]           prog_addr,
   input  logic [15:0]          prog_data,
   input  logic                 launch,
   input  logic [NUM_CORES-1:0] core_mask,
   input  logic [NUM_CORES-1:0] rtr,
   input  logic [NUM_CORES-1:0] ready,
   output logic [NUM_CORES-1:0] val_ins,
   output logic [15:0]          instruction,
   output logic                 busy,
   output logic                 done,
   output logic [NUM_CORES-1:0] active
);

   localparam logic [3:0] LAST_WORD = 4'(PROG_WORDS - 1);

   typedef enum logic [2:0] {IDLE, SCAN, LOAD, DRAIN, DONE} state_t;

   state_t               state;
   state_t               state_next;
   logic [NUM_CORES-1:0] pending;
   logic [NUM_CORES-1:0] cand;
   logic [NUM_CORES-1:0] pick;
   logic [3:0]           cnt;
   logic [15:0]          prog [PROG_WORDS];

   // Cores still waiting for the program that can accept it right now; the
   // two's-complement trick isolates the lowest such core as a one-hot mask.
   assign cand = pending & rtr;
   assign pick = cand & (~cand + NUM_CORES'(1));

   assign busy = (state == SCAN) || (state == LOAD) || (state == DRAIN);
   assign done = (state == DONE);

   // Program buffer: host writes only while idle, contents survive reset.
   always_ff @(posedge clk) begin
      if (prog_we && !busy) begin
         prog[prog_addr] <= prog_data;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: load cores one at a time, then drain until all are ready.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (launch) begin
               state_next = SCAN;
            end
         end
         SCAN: begin
            if (pending == '0) begin
               state_next = DRAIN;
            end else if (cand != '0) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (cnt == LAST_WORD) begin
               state_next = SCAN;
            end
         end
         DRAIN: begin
            if (active == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: the one-hot val_ins doubles as the mask of the core being
   // loaded, so finishing a burst retires it from pending and marks it active.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending     <= '0;
         active      <= '0;
         val_ins     <= '0;
         instruction <= 16'h0000;
         cnt         <= 4'd0;
      end else begin
         active <= active & ~ready;
         case (state)
            IDLE: begin
               if (launch) begin
                  pending <= core_mask;
                  active  <= '0;
               end
            end
            SCAN: begin
               if (cand != '0) begin
                  val_ins     <= pick;
                  instruction <= prog[0];
                  cnt         <= 4'd0;
               end
            end
            LOAD: begin
               if (cnt == LAST_WORD) begin
                  val_ins <= '0;
                  pending <= pending & ~val_ins;
                  active  <= (active & ~ready) | val_ins;
               end else begin
                  cnt         <= cnt + 4'd1;
                  instruction <= prog[cnt + 4'd1];
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpu_task_dispatcher.sv
// tb_gpu_task_dispatcher: directed checks of loading order, burst timing,
// completion tracking, busy-time write/launch blocking and mid-load reset.
module tb_gpu_task_dispatcher;

   localparam int NC = 16;

   logic          clk;
   logic          reset;
   logic          prog_we;
   logic [3:0]    prog_addr;
   logic [15:0]   prog_data;
   logic          launch;
   logic [NC-1:0] core_mask;
   logic [NC-1:0] rtr;
   logic [NC-1:0] ready;
   logic [NC-1:0] val_ins;
   logic [15:0]   instruction;
   logic          busy;
   logic          done;
   logic [NC-1:0] active;

   int checks = 0;
   int errors = 0;

   gpu_task_dispatcher #(.NUM_CORES(NC), .PROG_WORDS(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .launch      (launch),
      .core_mask   (core_mask),
      .rtr         (rtr),
      .ready       (ready),
      .val_ins     (val_ins),
      .instruction (instruction),
      .busy        (busy),
      .done        (done),
      .active      (active)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic nextCycle;
      @(posedge clk);
      #1;
   endtask

   // Pulses launch for one cycle; returns in the first SCAN cycle (T0+1).
   task automatic applyStimulus(input logic [NC-1:0] mask);
      core_mask = mask;
      launch    = 1'b1;
      nextCycle;
      launch    = 1'b0;
   endtask

   // Checks a full 16-word burst to one core; a core's stale ready drops on
   // its first word, and optionally another core's ready pulses mid-burst.
   task automatic checkBurst(input int core, input int pulseCore);
      for (int i = 0; i < 16; i++) begin
         nextCycle;
         if (i == 0 || i == 5) ready = '0;
         checkOutput("burst_val_ins", 32'(val_ins), 32'(1 << core));
         checkOutput("burst_word", 32'(instruction), 32'h1000 + 32'(i));
         if (i == 4 && pulseCore >= 0) ready = NC'(1) << pulseCore;
      end
   endtask

   initial begin
      reset     = 1'b1;
      prog_we   = 1'b0;
      prog_addr = 4'd0;
      prog_data = 16'h0000;
      launch    = 1'b0;
      core_mask = '0;
      rtr       = '1;
      ready     = '0;

      // Reset values
      #2;
      checkOutput("rst_val_ins", 32'(val_ins), 32'h0);
      checkOutput("rst_instruction", 32'(instruction), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_done", 32'(done), 32'h0);
      checkOutput("rst_active", 32'(active), 32'h0);
      nextCycle;
      nextCycle;
      reset = 1'b0;

      // Program load
      for (int i = 0; i < 16; i++) begin
         prog_we   = 1'b1;
         prog_addr = 4'(i);
         prog_data = 16'h1000 + 16'(i);
         nextCycle;
      end
      prog_we = 1'b0;
      nextCycle;

      // Single core, ready pulse at T0+40 gives done at T0+42
      applyStimulus(16'h0001);
      checkOutput("t1_busy_scan", 32'(busy), 32'h1);
      checkOutput("t1_val_scan", 32'(val_ins), 32'h0);
      checkBurst(0, -1);
      nextCycle;
      checkOutput("t1_val_after", 32'(val_ins), 32'h0);
      checkOutput("t1_active_set", 32'(active), 32'h1);
      repeat (22) nextCycle;
      checkOutput("t1_done_wait", 32'(done), 32'h0);
      checkOutput("t1_busy_wait", 32'(busy), 32'h1);
      ready = 16'h0001;
      nextCycle;
      ready = '0;
      checkOutput("t1_active_clr", 32'(active), 32'h0);
      checkOutput("t1_done_r1", 32'(done), 32'h0);
      checkOutput("t1_busy_r1", 32'(busy), 32'h1);
      nextCycle;
      checkOutput("t1_done_r2", 32'(done), 32'h1);
      checkOutput("t1_busy_r2", 32'(busy), 32'h0);
      nextCycle;
      checkOutput("t1_done_end", 32'(done), 32'h0);

      // Mask 4005: cores 0, 2, 14 in order; ready[0] arrives during core 2
      applyStimulus(16'h4005);
      checkBurst(0, -1);
      nextCycle;
      checkOutput("t2_gap0_val", 32'(val_ins), 32'h0);
      checkOutput("t2_gap0_active", 32'(active), 32'h0001);
      checkBurst(2, 0);
      nextCycle;
      checkOutput("t2_gap2_val", 32'(val_ins), 32'h0);
      checkOutput("t2_gap2_active", 32'(active), 32'h0004);
      checkBurst(14, -1);
      nextCycle;
      checkOutput("t2_gap14_val", 32'(val_ins), 32'h0);
      checkOutput("t2_gap14_active", 32'(active), 32'h4004);
      nextCycle;
      checkOutput("t2_drain_done", 32'(done), 32'h0);
      ready = 16'h0004;
      nextCycle;
      ready = '0;
      checkOutput("t2_active_c2", 32'(active), 32'h4000);
      checkOutput("t2_done_c2", 32'(done), 32'h0);
      nextCycle;
      checkOutput("t2_done_hold", 32'(done), 32'h0);
      ready = 16'h4000;
      nextCycle;
      ready = '0;
      checkOutput("t2_active_c14", 32'(active), 32'h0);
      checkOutput("t2_busy_c14", 32'(busy), 32'h1);
      nextCycle;
      checkOutput("t2_done", 32'(done), 32'h1);
      nextCycle;

      // Mask 0003 with rtr[0] low until T0+30
      rtr = 16'hFFFE;
      applyStimulus(16'h0003);
      checkBurst(1, -1);
      for (int t = 18; t <= 31; t++) begin
         nextCycle;
         checkOutput("t3_wait_val", 32'(val_ins), 32'h0);
         checkOutput("t3_wait_busy", 32'(busy), 32'h1);
      end
      checkOutput("t3_wait_active", 32'(active), 32'h0002);
      rtr = '1;
      checkBurst(0, -1);
      nextCycle;
      checkOutput("t3_active", 32'(active), 32'h0003);
      ready = 16'h0003;
      nextCycle;
      ready = '0;
      checkOutput("t3_active_clr", 32'(active), 32'h0);
      nextCycle;
      checkOutput("t3_done", 32'(done), 32'h1);
      nextCycle;

      // Stale ready[0] held through launch is not counted
      ready = 16'h0001;
      applyStimulus(16'h0001);
      checkOutput("t4_active_scan", 32'(active), 32'h0);
      checkBurst(0, -1);
      nextCycle;
      checkOutput("t4_active_set", 32'(active), 32'h0001);
      repeat (5) nextCycle;
      checkOutput("t4_done_wait", 32'(done), 32'h0);
      checkOutput("t4_active_wait", 32'(active), 32'h0001);
      ready = 16'h0001;
      nextCycle;
      ready = '0;
      checkOutput("t4_active_clr", 32'(active), 32'h0);
      nextCycle;
      checkOutput("t4_done", 32'(done), 32'h1);
      nextCycle;

      // Mask 0, with a launch and program write while busy
      applyStimulus('0);
      checkOutput("t5_busy_scan", 32'(busy), 32'h1);
      checkOutput("t5_val_scan", 32'(val_ins), 32'h0);
      launch    = 1'b1;
      core_mask = 16'h0001;
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = 16'hBEEF;
      nextCycle;
      checkOutput("t5_busy_drain", 32'(busy), 32'h1);
      checkOutput("t5_done_drain", 32'(done), 32'h0);
      nextCycle;
      launch  = 1'b0;
      prog_we = 1'b0;
      checkOutput("t5_done", 32'(done), 32'h1);
      checkOutput("t5_busy_done", 32'(busy), 32'h0);
      checkOutput("t5_val_done", 32'(val_ins), 32'h0);
      nextCycle;
      checkOutput("t5_done_end", 32'(done), 32'h0);
      nextCycle;
      checkOutput("t5_busy_idle", 32'(busy), 32'h0);
      checkOutput("t5_val_idle", 32'(val_ins), 32'h0);

      // Reset at word 7 of a load, then a full reload
      applyStimulus(16'h0001);
      for (int i = 0; i < 8; i++) begin
         nextCycle;
         checkOutput("t6_word", 32'(instruction), 32'h1000 + 32'(i));
      end
      reset = 1'b1;
      #1;
      checkOutput("t6_rst_val", 32'(val_ins), 32'h0);
      checkOutput("t6_rst_instr", 32'(instruction), 32'h0);
      checkOutput("t6_rst_busy", 32'(busy), 32'h0);
      checkOutput("t6_rst_done", 32'(done), 32'h0);
      checkOutput("t6_rst_active", 32'(active), 32'h0);
      #1;
      reset = 1'b0;
      nextCycle;
      checkOutput("t6_idle_busy", 32'(busy), 32'h0);
      applyStimulus(16'h0001);
      checkBurst(0, -1);
      nextCycle;
      checkOutput("t6_active", 32'(active), 32'h0001);
      ready = 16'h0001;
      nextCycle;
      ready = '0;
      nextCycle;
      checkOutput("t6_done", 32'(done), 32'h1);
      nextCycle;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
